// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 deserialiser that assembles BYTES bytes (first byte in the MSBs) into one frame,
// with start-bit validation, stop-bit check and inter-byte timeout. Define UART_RX_PARITY_EN for 8E1.
module uart_frame_rx #(
    parameter int SCYCLE       = 50000000,
    parameter int BAUDRATE     = 115200,
    parameter int BYTES        = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               iCLOCK,
    input  logic               iNRESET,
    input  logic               iRX,
    output logic               oRECEPT,
    output logic               oDONE,
    output logic [BYTES*8-1:0] oFDATA,
    output logic               oFERR,
    output logic               oTOUT,
    output logic [2:0]         oSTATE
);

    localparam int DIV  = SCYCLE / BAUDRATE;
    localparam int HALF = DIV / 2;
    localparam int TMO  = TIMEOUT_BITS * DIV;
    localparam int FW   = BYTES * 8;
    localparam int TW   = $clog2(DIV + 1);
    localparam int IW   = $clog2(TMO + 1);
    localparam int BW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
    localparam logic [TW-1:0] DIV_M1   = TW'(DIV - 1);
    localparam logic [IW-1:0] TMO_M1   = IW'(TMO - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t          state_q, state_nx;
    logic [TW-1:0]   timer_q, timer_nx;
    logic [IW-1:0]   idle_q, idle_nx;
    logic [2:0]      bit_q, bit_nx;
    logic [BW-1:0]   byte_q, byte_nx;
    logic [7:0]      shreg_q, shreg_nx;
    logic [FW-1:0]   frame_q, frame_nx;
    logic [FW-1:0]   fdata_q, fdata_nx;
    logic            recept_q, recept_nx;
    logic            done_nx, ferr_nx, tout_nx;

    logic            rx_m, rx_s, rx_d;
    logic            rx_fall;
    logic [FW+7:0]   frame_ext;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge iCLOCK or negedge iNRESET) begin
        if (!iNRESET) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= iRX;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign rx_fall   = rx_d & ~rx_s;
    assign frame_ext = {frame_q, shreg_q};

    always_ff @(posedge iCLOCK or negedge iNRESET) begin
        if (!iNRESET) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idle_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shreg_q  <= '0;
            frame_q  <= '0;
            fdata_q  <= '0;
            recept_q <= 1'b0;
            oDONE    <= 1'b0;
            oFERR    <= 1'b0;
            oTOUT    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            timer_q  <= timer_nx;
            idle_q   <= idle_nx;
            bit_q    <= bit_nx;
            byte_q   <= byte_nx;
            shreg_q  <= shreg_nx;
            frame_q  <= frame_nx;
            fdata_q  <= fdata_nx;
            recept_q <= recept_nx;
            oDONE    <= done_nx;
            oFERR    <= ferr_nx;
            oTOUT    <= tout_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        timer_nx  = timer_q + 1'b1;
        idle_nx   = idle_q;
        bit_nx    = bit_q;
        byte_nx   = byte_q;
        shreg_nx  = shreg_q;
        frame_nx  = frame_q;
        fdata_nx  = fdata_q;
        recept_nx = recept_q;
        done_nx   = 1'b0;
        ferr_nx   = 1'b0;
        tout_nx   = 1'b0;

        case (state_q)
            // A 1->0 edge needs rx_s to have been high, so after a framing
            // error the line must return to idle before a new frame starts.
            S_IDLE: begin
                timer_nx = '0;
                if (rx_fall) begin
                    state_nx  = S_START;
                    byte_nx   = '0;
                    frame_nx  = '0;
                    recept_nx = 1'b1;
                end
            end

            S_START: begin
                if (timer_q == HALF_M1) begin
                    timer_nx = '0;
                    if (!rx_s) begin
                        state_nx = S_DATA;
                        bit_nx   = '0;
                    end else begin
                        state_nx = S_IDLE;
                        if (byte_q == '0) recept_nx = 1'b0;
                    end
                end
            end

            S_DATA: begin
                if (timer_q == DIV_M1) begin
                    timer_nx = '0;
                    shreg_nx = {rx_s, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end else begin
                        bit_nx = bit_q + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            S_PARITY: begin
                if (timer_q == DIV_M1) begin
                    timer_nx = '0;
                    if (^{shreg_q, rx_s}) begin
                        state_nx  = S_IDLE;
                        ferr_nx   = 1'b1;
                        frame_nx  = '0;
                        byte_nx   = '0;
                        recept_nx = 1'b0;
                    end else begin
                        state_nx = S_STOP;
                    end
                end
            end
`endif

            S_STOP: begin
                if (timer_q == DIV_M1) begin
                    timer_nx = '0;
                    if (!rx_s) begin
                        state_nx  = S_IDLE;
                        ferr_nx   = 1'b1;
                        frame_nx  = '0;
                        byte_nx   = '0;
                        recept_nx = 1'b0;
                    end else if (byte_q == LAST_IDX) begin
                        state_nx  = S_IDLE;
                        fdata_nx  = frame_ext[FW-1:0];
                        done_nx   = 1'b1;
                        frame_nx  = '0;
                        byte_nx   = '0;
                        recept_nx = 1'b0;
                    end else begin
                        state_nx = S_GAP;
                        frame_nx = frame_ext[FW-1:0];
                        byte_nx  = byte_q + 1'b1;
                        idle_nx  = '0;
                    end
                end
            end

            S_GAP: begin
                timer_nx = '0;
                if (rx_fall) begin
                    state_nx = S_START;
                    idle_nx  = '0;
                end else if (rx_s) begin
                    if (idle_q == TMO_M1) begin
                        state_nx  = S_IDLE;
                        tout_nx   = 1'b1;
                        frame_nx  = '0;
                        byte_nx   = '0;
                        idle_nx   = '0;
                        recept_nx = 1'b0;
                    end else begin
                        idle_nx = idle_q + 1'b1;
                    end
                end
            end

            default: begin
                state_nx  = S_IDLE;
                timer_nx  = '0;
                recept_nx = 1'b0;
            end
        endcase
    end

    assign oRECEPT = recept_q;
    assign oFDATA  = fdata_q;
    assign oSTATE  = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at a reduced bit period (DIV=32) so whole frames run quickly.
module tb_uart_frame_rx;

    localparam int SCYCLE       = 3200000;
    localparam int BAUDRATE     = 100000;
    localparam int BYTES        = 8;
    localparam int TIMEOUT_BITS = 20;
    localparam int DIV          = 32;
    localparam int HALF         = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Receive window: first start edge to the mid-point of the last stop bit.
    localparam int RECEPT_LEN = (BYTES - 1) * NB * DIV + (NB - 1) * DIV + HALF;
    // Last stop bit end to oTOUT: half a bit early plus sync/register delay.
    localparam int TOUT_LAT   = TIMEOUT_BITS * DIV - HALF + 3;

    localparam logic [63:0] F1  = 64'h0000_03E8_DEAD_BEEF;
    localparam logic [63:0] F2A = 64'h0001_03E8_0000_0000;
    localparam logic [63:0] F2B = 64'h0002_0000_0000_0001;
    localparam logic [63:0] F3  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] F4  = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] F5  = 64'hCAFE_BABE_1234_5678;
    localparam logic [63:0] F6  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] F7  = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] F8  = 64'h8000_0000_0000_0001;

    logic        clk;
    logic        iNRESET;
    logic        iRX;
    logic        oRECEPT, oDONE, oFERR, oTOUT;
    logic [63:0] oFDATA;
    logic [2:0]  oSTATE;

    int checks   = 0;
    int failures = 0;

    int          cyc = 0;
    int          done_cnt = 0, ferr_cnt = 0, tout_cnt = 0, excl_cnt = 0;
    int          tout_cyc = 0, run = 0, last_run = 0;
    logic [63:0] last_fdata = '0, prev_fdata = '0;
`ifdef UART_RX_PARITY_EN
    int          par_bad_idx = -1;
`endif

    uart_frame_rx #(
        .SCYCLE(SCYCLE), .BAUDRATE(BAUDRATE), .BYTES(BYTES), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .iCLOCK (clk),
        .iNRESET(iNRESET),
        .iRX    (iRX),
        .oRECEPT(oRECEPT),
        .oDONE  (oDONE),
        .oFDATA (oFDATA),
        .oFERR  (oFERR),
        .oTOUT  (oTOUT),
        .oSTATE (oSTATE)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (oDONE) begin
            done_cnt   = done_cnt + 1;
            prev_fdata = last_fdata;
            last_fdata = oFDATA;
        end
        if (oFERR) ferr_cnt = ferr_cnt + 1;
        if (oTOUT) begin
            tout_cnt = tout_cnt + 1;
            tout_cyc = cyc;
        end
        if (int'(oDONE) + int'(oFERR) + int'(oTOUT) > 1) excl_cnt = excl_cnt + 1;
        if (oRECEPT) run = run + 1;
        else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle_bits(input int n);
        iRX = 1'b1;
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_flip);
        iRX = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            iRX = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        iRX = (^b) ^ par_flip;
        repeat (DIV) @(negedge clk);
`endif
        iRX = stop_v;
        repeat (DIV) @(negedge clk);
        iRX = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] f, input int nbytes, input int bad_stop_idx);
        logic pf;
        for (int k = 0; k < nbytes; k++) begin
            pf = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf = (k == par_bad_idx);
`endif
            send_byte(f[63-8*k -: 8], (k == bad_stop_idx) ? 1'b0 : 1'b1, pf);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iNRESET = 1'b0;
        iRX     = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({oRECEPT, oDONE, oFERR, oTOUT} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {oRECEPT, oDONE, oFERR, oTOUT});
        end
        checks++;
        if (oFDATA !== 64'h0) begin
            failures++;
            $display("FAIL reset_fdata: got %h expected 0", oFDATA);
        end
        checks++;
        if (oSTATE !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", oSTATE);
        end
        iNRESET = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_single_frame();
        int d0, e0, t0;
        d0 = done_cnt; e0 = ferr_cnt; t0 = tout_cnt;
        send_frame(F1, BYTES, -1);
        idle_bits(2);
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (last_fdata !== F1) begin
            failures++;
            $display("FAIL single_fdata: got %h expected %h", last_fdata, F1);
        end
        checks++;
        if (last_run < RECEPT_LEN - 2 || last_run > RECEPT_LEN + 2) begin
            failures++;
            $display("FAIL single_recept_len: got %0d expected %0d", last_run, RECEPT_LEN);
        end
        checks++;
        if ((ferr_cnt - e0) + (tout_cnt - t0) !== 0) begin
            failures++;
            $display("FAIL single_no_err: got %0d expected 0", (ferr_cnt - e0) + (tout_cnt - t0));
        end
        checks++;
        if (oFDATA !== F1) begin
            failures++;
            $display("FAIL single_fdata_hold: got %h expected %h", oFDATA, F1);
        end
    endtask

    task automatic test_back_to_back();
        int d0, e0, t0;
        d0 = done_cnt; e0 = ferr_cnt; t0 = tout_cnt;
        send_frame(F2A, BYTES, -1);
        send_frame(F2B, BYTES, -1);
        idle_bits(2);
        checks++;
        if (done_cnt - d0 !== 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
        end
        checks++;
        if (prev_fdata !== F2A) begin
            failures++;
            $display("FAIL b2b_first_fdata: got %h expected %h", prev_fdata, F2A);
        end
        checks++;
        if (last_fdata !== F2B) begin
            failures++;
            $display("FAIL b2b_second_fdata: got %h expected %h", last_fdata, F2B);
        end
        checks++;
        if ((ferr_cnt - e0) + (tout_cnt - t0) !== 0) begin
            failures++;
            $display("FAIL b2b_no_err: got %0d expected 0", (ferr_cnt - e0) + (tout_cnt - t0));
        end
    endtask

    task automatic test_framing_error();
        int d0, e0;
        d0 = done_cnt; e0 = ferr_cnt;
        send_frame(F3, 4, 3);
        idle_bits(3);
        checks++;
        if (ferr_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - e0);
        end
        checks++;
        if (done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0);
        end
        checks++;
        if (oFDATA !== F2B) begin
            failures++;
            $display("FAIL ferr_fdata_hold: got %h expected %h", oFDATA, F2B);
        end
        checks++;
        if ({oRECEPT, oSTATE} !== 4'b0000) begin
            failures++;
            $display("FAIL ferr_idle: got recept=%b state=%0d expected 0/0", oRECEPT, oSTATE);
        end
        d0 = done_cnt;
        send_frame(F4, BYTES, -1);
        idle_bits(2);
        checks++;
        if (done_cnt - d0 !== 1 || last_fdata !== F4) begin
            failures++;
            $display("FAIL ferr_recover: got done=%0d fdata=%h expected 1 %h", done_cnt - d0, last_fdata, F4);
        end
    endtask

    task automatic test_timeout();
        int d0, t0, mark;
        d0 = done_cnt; t0 = tout_cnt;
        send_frame(F5, 4, -1);
        mark = cyc;
        idle_bits(25);
        checks++;
        if (tout_cnt - t0 !== 1) begin
            failures++;
            $display("FAIL tout_count: got %0d expected 1", tout_cnt - t0);
        end
        checks++;
        if (tout_cyc - mark < TOUT_LAT - 4 || tout_cyc - mark > TOUT_LAT + 4) begin
            failures++;
            $display("FAIL tout_latency: got %0d expected %0d", tout_cyc - mark, TOUT_LAT);
        end
        checks++;
        if (oRECEPT !== 1'b0 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL tout_abort: got recept=%b done=%0d expected 0 0", oRECEPT, done_cnt - d0);
        end
        checks++;
        if (oFDATA !== F4) begin
            failures++;
            $display("FAIL tout_fdata_hold: got %h expected %h", oFDATA, F4);
        end
        send_frame(F6, BYTES, -1);
        idle_bits(2);
        checks++;
        if (done_cnt - d0 !== 1 || last_fdata !== F6) begin
            failures++;
            $display("FAIL tout_recover: got done=%0d fdata=%h expected 1 %h", done_cnt - d0, last_fdata, F6);
        end
    endtask

    task automatic test_glitch();
        int d0, e0, t0;
        d0 = done_cnt; e0 = ferr_cnt; t0 = tout_cnt;
        iRX = 1'b0;
        repeat (10) @(negedge clk);
        idle_bits(2);
        checks++;
        if ((done_cnt - d0) + (ferr_cnt - e0) + (tout_cnt - t0) !== 0) begin
            failures++;
            $display("FAIL glitch_no_pulse: got %0d expected 0", (done_cnt - d0) + (ferr_cnt - e0) + (tout_cnt - t0));
        end
        checks++;
        if (last_run < HALF - 1 || last_run > HALF + 1) begin
            failures++;
            $display("FAIL glitch_start_window: got %0d expected %0d", last_run, HALF);
        end
        checks++;
        if ({oRECEPT, oSTATE} !== 4'b0000 || oFDATA !== F6) begin
            failures++;
            $display("FAIL glitch_idle: got recept=%b state=%0d fdata=%h expected 0 0 %h", oRECEPT, oSTATE, oFDATA, F6);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        d0 = done_cnt;
        send_frame(F7, 4, -1);
        iRX = 1'b0;
        repeat (DIV) @(negedge clk);
        iRX = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        iRX = 1'b0;
        repeat (DIV) @(negedge clk);
        iNRESET = 1'b0;
        #1;
        checks++;
        if ({oRECEPT, oDONE, oFERR, oTOUT} !== 4'b0000 || oFDATA !== 64'h0 || oSTATE !== 3'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got flags=%b fdata=%h state=%0d expected all 0",
                     {oRECEPT, oDONE, oFERR, oTOUT}, oFDATA, oSTATE);
        end
        repeat (3) @(negedge clk);
        iRX     = 1'b1;
        iNRESET = 1'b1;
        idle_bits(3);
        checks++;
        if (done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL midreset_no_done: got %0d expected 0", done_cnt - d0);
        end
        send_frame(F8, BYTES, -1);
        idle_bits(2);
        checks++;
        if (done_cnt - d0 !== 1 || last_fdata !== F8) begin
            failures++;
            $display("FAIL midreset_recover: got done=%0d fdata=%h expected 1 %h", done_cnt - d0, last_fdata, F8);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int d0, e0;
        d0 = done_cnt; e0 = ferr_cnt;
        par_bad_idx = 2;
        send_frame(F1, 3, -1);
        par_bad_idx = -1;
        idle_bits(3);
        checks++;
        if (ferr_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL parity_err: got ferr=%0d done=%0d expected 1 0", ferr_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (oFDATA !== F8 || oRECEPT !== 1'b0) begin
            failures++;
            $display("FAIL parity_discard: got fdata=%h recept=%b expected %h 0", oFDATA, oRECEPT, F8);
        end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        iNRESET = 1'b0;
        iRX     = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_framing_error();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (excl_cnt !== 0) begin
            failures++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", excl_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
